add_seq_ctrl: RTL and testbench
===============================

# add_seq_ctrl

Multi-cycle add sequencer that runs wide additions through one shared 4-bit ripple adder, one nibble per clock. The low nibble goes first, and the carry is registered between nibbles. Operands arrive and results leave on valid/ready handshakes. It sits between a requesting datapath stage and the 4-bit adder slice, and replaces a full-width adder where area matters more than latency.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- IN_VALID  input  1  the operand set is valid.
- IN_READY  output  1  the block can accept operands; high only in IDLE.
- A  input  W  operand A.
- B  input  W  operand B.
- CIN  input  1  carry-in to nibble 0.
- SUB  input  1  subtract request; has an effect only under ADD_SEQ_SUB_EN.
- OUT_VALID  output  1  the result is valid; high only in DONE.
- OUT_READY  input  1  the consumer accepts the result.
- SUM  output  W  result.
- COUT  output  1  carry out of the top nibble.
- OVF  output  1  two's-complement overflow.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - IN_READY=1.
  - When IN_VALID=1 at the clock edge, the block registers A, B' and the initial carry, sets idx=0, and goes to RUN.
  - B' = B. The initial carry is CIN.
- **RUN:**
  - Each cycle the adder receives C0=carry, X=A[4*idx+:4], Y=B'[4*idx+:4].
  - At the edge, SUM[4*idx+:4] takes the adder S output and carry takes C4.
  - If idx==NIBBLES-1, the block latches COUT=C4 and OVF, then goes to DONE. Otherwise idx increments.
- **DONE:**
  - OUT_VALID=1. SUM, COUT and OVF hold steady.
  - When OUT_READY=1 at the edge, the block goes to IDLE.
  - SUM, COUT and OVF keep their values after leaving DONE. They are valid only while OUT_VALID=1.
- **Overflow:** OVF = (A[W-1]==B'[W-1]) && (SUM[W-1]!=A[W-1]), evaluated on the final nibble.
- **Width rules:**
  - The sum is modulo 2^W.
  - idx is a counter of width clog2(NIBBLES), minimum 1 bit. It never reaches NIBBLES.
- **Inputs outside IDLE:** IN_VALID is ignored in RUN and DONE. A, B, CIN and SUB are sampled only at the accept edge, so they may change freely afterwards.
- **Simultaneous events:** OUT_READY and IN_VALID both high in DONE → the block only retires the result. The new operands are accepted no earlier than the following IDLE cycle.
- **Reset values:**
  - The state goes to IDLE, and idx, carry, SUM, COUT and OVF go to 0.
  - OUT_VALID=0 and IN_READY=1.
  - No capture occurs while RST is high.
- **Reset mid-operation:** RST asserted in RUN or DONE aborts the operation at once. The partial result is discarded and no OUT_VALID pulse occurs.

## Timing
- **Accept:** the edge where IN_VALID and IN_READY are both high is edge 0.
- **Processing:** RUN occupies edges 1..NIBBLES.
- **Result:** OUT_VALID rises after edge NIBBLES, i.e. NIBBLES cycles after the accept edge.
- **Throughput:** with OUT_READY tied high, one operation every NIBBLES+2 cycles.
- **Output paths:** OUT_VALID, IN_READY and all result outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- **ADD_SEQ_SUB_EN defined:**
  - SUB=1 at accept loads B' = ~B with initial carry 1, so SUM = A-B-... with CIN ignored; the exact result is SUM = A-B.
  - COUT=1 means no borrow.
  - OVF follows the same formula applied to B'.
- **ADD_SEQ_SUB_EN undefined:**
  - The SUB port remains but is ignored.
  - B' = B and the initial carry is CIN.
  - The inversion logic is absent.

## Structure
- **Package add_seq_pkg:**
  - the state enum (IDLE, RUN, DONE);
  - NIBBLE_W=4;
  - a helper function for the idx width.
- **Sub-module:** one instance of the team's 4-bit ripple adder FULL_ADDER (C0, X, Y, S, C4), driven by the nibble mux. The controller contains no other arithmetic besides the OVF compare and the optional inversion.

## Test plan
- A=0x1234, B=0x4321, CIN=0 → SUM=0x5555, COUT=0, OVF=0; OUT_VALID rises exactly 4 cycles after the accept edge.
- A=0xFFFF, B=0x0001, CIN=0 → SUM=0x0000, COUT=1, OVF=0; checks the carry chained through all four nibbles.
- A=0x7FFF, B=0x0001, CIN=0 → SUM=0x8000, COUT=0, OVF=1.
- Hold OUT_READY low 5 cycles in DONE while pulsing IN_VALID → SUM is stable, IN_READY=0, and no second capture occurs. After OUT_READY=1 → IDLE, and the next operand set yields the correct result.
- Assert RST during the 2nd RUN cycle → the same cycle shows OUT_VALID=0, SUM=0 and IN_READY=1. A fresh A=0x0F0F, B=0x0101 → SUM=0x1010.
- With ADD_SEQ_SUB_EN: A=0x0005, B=0x0007, SUB=1 → SUM=0xFFFE, COUT=0, OVF=0. Without it, the same stimulus → SUM=0x000C.

Source files
------------

// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Nibble index width; a single-nibble build still needs one bit.
    function automatic int idx_w(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Operand/result handshake bundle for add_seq_ctrl; slave = sequencer, master = requester.
interface add_seq_ctrl_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
    logic         SUB;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] SUM;
    logic         COUT;
    logic         OVF;

    modport slave (
        input  IN_VALID, A, B, CIN, SUB, OUT_READY,
        output IN_READY, OUT_VALID, SUM, COUT, OVF
    );

    modport master (
        output IN_VALID, A, B, CIN, SUB, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, COUT, OVF
    );
endinterface

// File: rtl/add_seq_ctrl_full_adder.sv
// 4-bit ripple-carry adder slice: purely combinational, no handshake.
// Latency: zero cycles; backpressure: not applicable.
module FULL_ADDER (
    input  logic       C0,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] S,
    output logic       C4
);
    logic [4:0] w_c;

    always_comb begin
        w_c    = '0;
        S      = '0;
        w_c[0] = C0;
        for (int i = 0; i < 4; i++) begin
            S[i]     = X[i] ^ Y[i] ^ w_c[i];
            w_c[i+1] = (X[i] & Y[i]) | (w_c[i] & (X[i] ^ Y[i]));
        end
        C4 = w_c[4];
    end
endmodule

// File: rtl/add_seq_ctrl.sv
// Wide add through one shared 4-bit adder, low nibble first; ADD_SEQ_SUB_EN enables SUB.
// Latency: OUT_VALID rises NIBBLES cycles after the accept edge.
// Backpressure: accepts only in IDLE; result held in DONE until OUT_READY.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic          CLK,
    input  logic          RST,
    add_seq_ctrl_if.slave bus
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [W-1:0]        w_b_load;
    logic                w_c_load;
    logic [NIBBLE_W-1:0] w_x;
    logic [NIBBLE_W-1:0] w_y;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_c4;
    logic                w_last;
    logic                w_accept;

`ifdef ADD_SEQ_SUB_EN
    // Subtract as A + ~B + 1; CIN is deliberately dropped in that case.
    assign w_b_load = bus.SUB ? ~bus.B : bus.B;
    assign w_c_load = bus.SUB ? 1'b1   : bus.CIN;
`else
    logic w_unused_sub;
    assign w_unused_sub = bus.SUB;
    assign w_b_load     = bus.B;
    assign w_c_load     = bus.CIN;
`endif

    assign w_accept = (r_state == IDLE) && bus.IN_VALID;
    assign w_last   = (r_idx == IDX_LAST);
    assign w_x      = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_y      = r_b[NIBBLE_W*r_idx +: NIBBLE_W];

    FULL_ADDER u_adder (
        .C0 (r_carry),
        .X  (w_x),
        .Y  (w_y),
        .S  (w_s),
        .C4 (w_c4)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.IN_VALID)  w_state_nxt = RUN;
            RUN:     if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.OUT_READY) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_s;
            r_carry <= w_c4;
            if (w_last) begin
                r_cout <= w_c4;
                // Sign of the result comes straight from the top nibble's S[3].
                r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_s[NIBBLE_W-1] != r_a[W-1]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.IN_READY  = (r_state == IDLE);
    assign bus.OUT_VALID = (r_state == DONE);
    assign bus.SUM       = r_sum;
    assign bus.COUT      = r_cout;
    assign bus.OVF       = r_ovf;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: directed cases plus random operands against an arithmetic model.
module tb_add_seq_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
`ifdef ADD_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    add_seq_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    add_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain W+1-bit arithmetic on the effective operand.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output logic [W-1:0] sum, output logic cout,
                         output logic ovf);
        logic [W:0]   full;
        logic [W-1:0] bp;
        logic         c;
        bp   = (sub && SUB_EN) ? ~b : b;
        c    = (sub && SUB_EN) ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c};
        sum  = full[W-1:0];
        cout = full[W];
        ovf  = (a[W-1] == bp[W-1]) && (sum[W-1] != a[W-1]);
    endtask

    // Present operands, accept, wait for OUT_VALID (bounded), check result; leaves DUT in DONE.
    task automatic start_and_wait(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
        int           lat;
        model(a, b, cin, sub, esum, ecout, eovf);
        @(negedge CLK);
        chk({tag, ".in_ready"}, 64'(bus.IN_READY), 64'd1);
        bus.IN_VALID = 1'b1;
        bus.A = a; bus.B = b; bus.CIN = cin; bus.SUB = sub;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        bus.A = W'($urandom); bus.B = W'($urandom);
        bus.CIN = 1'($urandom); bus.SUB = 1'($urandom);
        lat = -1;
        for (int k = 1; k <= 3 * NIBBLES; k++) begin
            @(posedge CLK);
            #1;
            if (bus.OUT_VALID) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".latency"}, 64'(lat), 64'(NIBBLES));
        chk({tag, ".sum"},  64'(bus.SUM),  64'(esum));
        chk({tag, ".cout"}, 64'(bus.COUT), 64'(ecout));
        chk({tag, ".ovf"},  64'(bus.OVF),  64'(eovf));
    endtask

    task automatic retire();
        @(negedge CLK);
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        start_and_wait(tag, a, b, cin, sub);
        retire();
        chk({tag, ".retired"}, 64'(bus.OUT_VALID), 64'd0);
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_errors = 0;
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        bus.A = '0; bus.B = '0; bus.CIN = 1'b0; bus.SUB = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.in_ready",  64'(bus.IN_READY),  64'd1);
        chk("rst.out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst.sum",       64'(bus.SUM),       64'd0);
        chk("rst.cout",      64'(bus.COUT),      64'd0);
        chk("rst.ovf",       64'(bus.OVF),       64'd0);
        @(negedge CLK);
        RST = 1'b0;

        run_op("plain",   16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op("carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op("cin",     16'h00FF, 16'h0000, 1'b1, 1'b0);
        run_op("negovf",  16'h8000, 16'h8000, 1'b0, 1'b0);

        // Stall in DONE while IN_VALID pulses; nothing new may be captured.
        start_and_wait("hold", 16'hA5A5, 16'h1111, 1'b0, 1'b0);
        held_sum = bus.SUM;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bus.IN_VALID = i[0];
            bus.A = W'($urandom); bus.B = W'($urandom);
            @(posedge CLK);
            #1;
            chk("hold.sum",       64'(bus.SUM),       64'(held_sum));
            chk("hold.in_ready",  64'(bus.IN_READY),  64'd0);
            chk("hold.out_valid", 64'(bus.OUT_VALID), 64'd1);
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b1;
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b0;
        chk("simul.in_ready",  64'(bus.IN_READY),  64'd1);
        chk("simul.out_valid", 64'(bus.OUT_VALID), 64'd0);
        @(posedge CLK);
        #1;
        chk("simul.no_capture", 64'(bus.IN_READY), 64'd1);
        run_op("after_hold", 16'h0F0F, 16'h7070, 1'b1, 1'b0);

        // Reset landing in the second RUN cycle.
        @(negedge CLK);
        bus.IN_VALID = 1'b1;
        bus.A = 16'h1357; bus.B = 16'h2468; bus.CIN = 1'b0; bus.SUB = 1'b0;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("midrst.sum",       64'(bus.SUM),       64'd0);
        chk("midrst.in_ready",  64'(bus.IN_READY),  64'd1);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            @(posedge CLK);
            #1;
            chk("midrst.no_pulse", 64'(bus.OUT_VALID), 64'd0);
        end
        run_op("fresh", 16'h0F0F, 16'h0101, 1'b0, 1'b0);

        run_op("sub", 16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op("sub_cin", 16'h8000, 16'h0001, 1'b1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("rand", ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
